// File: rtl/vgafb_arbiter_pkg.sv
// rtl/vgafb_arbiter_pkg.sv - types and constants shared by the frame-buffer arbiter and its write buffer
`include "vga_defines.vh"

package vgafb_arbiter_pkg;

  localparam int FB_AW = `VGA_FB_AW;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_ACK,
    WR_ACK
  } cpu_state_e;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [3:0]       be;
    logic [31:0]      data;
  } wrbuf_entry_t;

endpackage

// File: rtl/vga_defines.vh
// rtl/vga_defines.vh - shared frame-buffer geometry and address-width constants
`ifndef VGA_DEFINES_VH
`define VGA_DEFINES_VH

`define VGA_COLS          80
`define VGA_ROWS          30
`define VGA_SYMS_PER_WORD 2
`define VGA_FB_WORDS      1200
`define VGA_FB_AW         11

`endif

// File: rtl/vgafb_wrbuf.sv
// rtl/vgafb_wrbuf.sv - CPU write FIFO holding {addr,be,data} entries; push and pop may coincide when full
module vgafb_wrbuf
  import vgafb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [FB_AW-1:0] push_addr,
  input  logic [3:0]       push_be,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output logic [FB_AW-1:0] head_addr,
  output logic [3:0]       head_be,
  output logic [31:0]      head_data,
  output logic             full,
  output logic             empty
);

  localparam int IW = $clog2(DEPTH);

  wrbuf_entry_t     slots [DEPTH];
  wrbuf_entry_t     head;
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  assign head      = slots[rd_ptr[IW-1:0]];
  assign head_addr = head.addr;
  assign head_be   = head.be;
  assign head_data = head.data;

  // Advance pointers; the caller never pushes when full without popping, nor pops when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; a full-FIFO push reuses the slot the head is leaving this cycle.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr[IW-1:0]] <= '{addr: push_addr, be: push_be, data: push_data};
  end

endmodule

// File: rtl/vgafb_arbiter.sv
// rtl/vgafb_arbiter.sv - single-port frame-buffer arbiter, scan-out priority over CPU; VGAFB_ARB_WRBUF_EN adds a write FIFO
`include "vga_defines.vh"

module vgafb_arbiter
  import vgafb_arbiter_pkg::*;
#(
  parameter int FB_WORDS    = `VGA_FB_WORDS,
  parameter int WRBUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vga_en,
  input  logic [FB_AW-1:0] vga_addr,
  output logic [31:0]      vga_rdata,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [FB_AW-1:0] cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_be,
  output logic             cpu_ack,
  output logic [31:0]      cpu_rdata,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [FB_AW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [FB_AW:0] FB_LIMIT = (FB_AW+1)'(FB_WORDS);

  cpu_state_e state_q;
  cpu_state_e state_d;
  logic       in_range;
  logic       rd_go;
  logic       wr_go;
  logic       buf_empty;
  logic       rd_oor_q;

  assign in_range  = ({1'b0, cpu_addr} < FB_LIMIT);
  assign vga_rdata = mem_rdata;

  // Reads wait for the write buffer to drain so they observe every earlier write.
  assign rd_go = (state_q == IDLE) && cpu_req && !cpu_we && !vga_en && buf_empty;

`ifdef VGAFB_ARB_WRBUF_EN
  logic             buf_full;
  logic             buf_push;
  logic             buf_pop;
  logic [FB_AW-1:0] head_addr;
  logic [3:0]       head_be;
  logic [31:0]      head_data;

  // Drain whenever scan-out leaves the port free and no CPU read result is in flight.
  assign buf_pop  = !buf_empty && !vga_en && (state_q != RD_WAIT);
  assign wr_go    = (state_q == IDLE) && cpu_req && cpu_we && (!buf_full || buf_pop);
  // Out-of-range and zero-enable writes are acknowledged but never enter the buffer.
  assign buf_push = wr_go && in_range && (cpu_be != 4'b0000);

  vgafb_wrbuf #(
    .DEPTH(WRBUF_DEPTH)
  ) u_wrbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_addr (cpu_addr),
    .push_be   (cpu_be),
    .push_data (cpu_wdata),
    .pop       (buf_pop),
    .head_addr (head_addr),
    .head_be   (head_be),
    .head_data (head_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );
`else
  logic unused_wrbuf_depth;

  assign unused_wrbuf_depth = ^WRBUF_DEPTH;
  assign buf_empty          = 1'b1;
  assign wr_go              = (state_q == IDLE) && cpu_req && cpu_we && !vga_en;
`endif

  // CPU FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // CPU FSM next state; requests are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_go)      state_d = RD_WAIT;
        else if (wr_go) state_d = WR_ACK;
      end
      RD_WAIT: state_d = RD_ACK;
      RD_ACK:  state_d = IDLE;
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux and ack: scan-out first, then buffered write, then the CPU access.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vga_en) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
    end
`ifdef VGAFB_ARB_WRBUF_EN
    else if (buf_pop) begin
      mem_en    = 1'b1;
      mem_we    = head_be;
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
`endif
    else if (rd_go && in_range) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr;
    end
`ifndef VGAFB_ARB_WRBUF_EN
    else if (wr_go && in_range && (cpu_be != 4'b0000)) begin
      mem_en    = 1'b1;
      mem_we    = cpu_be;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
`endif
    cpu_ack = (state_q == RD_ACK) || (state_q == WR_ACK);
  end

  // Read data capture; an out-of-range read returns zero instead of whatever the RAM drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= '0;
      rd_oor_q  <= 1'b0;
    end else begin
      if (rd_go)               rd_oor_q  <= !in_range;
      if (state_q == RD_WAIT)  cpu_rdata <= rd_oor_q ? 32'h0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_vgafb_arbiter.sv
// tb/tb_vgafb_arbiter.sv - directed self-checking bench for vgafb_arbiter with a behavioural RAM
module tb_vgafb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_en;
  logic [10:0] vga_addr;
  logic [31:0] vga_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ram [0:2047];
  logic [31:0] ram_rdata = 32'h0;
  logic        load_en   = 1'b0;
  logic [10:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [14:0] acc_q [$];

  always #5 clk = ~clk;

  vgafb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .vga_en    (vga_en),
    .vga_addr  (vga_addr),
    .vga_rdata (vga_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = ram_rdata;

  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      ram_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en) acc_q.push_back({mem_we, mem_addr});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [10:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    next_cycle();
    load_en = 1'b0;
  endtask

  task automatic cpu_start(input logic we, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  // cyc = number of cycles up to and including the ack cycle, counting the current one; 0 on timeout.
  task automatic wait_ack(input int budget, output int cyc, output logic [31:0] rd);
    cyc = 0;
    rd  = 32'h0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cyc = i;
        rd  = cpu_rdata;
        break;
      end
      next_cycle();
    end
    if (cyc != 0) next_cycle();
  endtask

  int          cyc;
  logic [31:0] rd;

  initial begin
    reset = 1'b1; vga_en = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    next_cycle();
    poke(11'd5,    32'hDEADBEEF);
    poke(11'd7,    32'h07070707);
    poke(11'd9,    32'h09090909);
    poke(11'd3,    32'hAAAAAAAA);
    poke(11'd1300, 32'h55555555);
    next_cycle();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_cpu_ack",   {31'b0, cpu_ack}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata,        32'h0);
    check("rst_mem_en",    {31'b0, mem_en},  32'h0);
    check("rst_mem_we",    {28'b0, mem_we},  32'h0);
    check("rst_mem_addr",  {21'b0, mem_addr}, 32'h0);
    next_cycle();

    // plain read, scan-out idle
    acc_q.delete();
    cpu_start(1'b0, 11'd5, 32'h0, 4'h0);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("rd5_cycles", cyc, 32'd3);
    check("rd5_data",   rd,  32'hDEADBEEF);
    check("rd5_nacc",   acc_q.size(), 32'd1);
    check("rd5_acc0",   {17'b0, acc_q[0]}, {17'b0, 4'h0, 11'd5});
    @(negedge clk);
    check("rd5_idle_mem_en", {31'b0, mem_en}, 32'h0);
    next_cycle();

    // read collides with scan-out
    acc_q.delete();
    cpu_start(1'b0, 11'd7, 32'h0, 4'h0);
    vga_en = 1'b1; vga_addr = 11'd9;
    next_cycle();
    vga_en = 1'b0;
    check("vga9_rdata", vga_rdata, 32'h09090909);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("rd7_cycles", 1 + cyc, 32'd4);
    check("rd7_data",   rd, 32'h07070707);
    check("rd7_nacc",   acc_q.size(), 32'd2);
    check("rd7_acc0",   {17'b0, acc_q[0]}, {17'b0, 4'h0, 11'd9});
    check("rd7_acc1",   {17'b0, acc_q[1]}, {17'b0, 4'h0, 11'd7});
    next_cycle();

    // out-of-range write and read
    acc_q.delete();
    cpu_start(1'b1, 11'd1300, 32'hCAFEF00D, 4'hF);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("oor_wr_cycles", cyc, 32'd2);
    repeat (3) next_cycle();
    check("oor_wr_nacc", acc_q.size(), 32'd0);
    cpu_start(1'b0, 11'd1300, 32'h0, 4'h0);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("oor_rd_cycles", cyc, 32'd3);
    check("oor_rd_data",   rd,  32'h0);
    check("oor_rd_nacc",   acc_q.size(), 32'd0);
    next_cycle();

    // byte-enable merge
    cpu_start(1'b1, 11'd3, 32'h11223344, 4'b0101);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("be_wr_cycles", cyc, 32'd2);
    cpu_start(1'b0, 11'd3, 32'h0, 4'h0);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("be_rd_cycles", cyc, 32'd3);
    check("be_rd_data",   rd,  32'hAA22AA44);
    next_cycle();

    // zero byte-enable write has no RAM effect
    acc_q.delete();
    cpu_start(1'b1, 11'd3, 32'hFFFFFFFF, 4'b0000);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("be0_wr_cycles", cyc, 32'd2);
    repeat (3) next_cycle();
    check("be0_wr_nacc", acc_q.size(), 32'd0);
    cpu_start(1'b0, 11'd3, 32'h0, 4'h0);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("be0_rd_data", rd, 32'hAA22AA44);
    next_cycle();

`ifdef VGAFB_ARB_WRBUF_EN
    // buffer fills while scan-out holds the port, then drains in order
    vga_en = 1'b1; vga_addr = 11'd0;
    for (int i = 0; i < 4; i++) begin
      cpu_start(1'b1, 11'(20 + i), 32'h100 + i, 4'hF);
      wait_ack(20, cyc, rd);
      cpu_req = 1'b0;
      check($sformatf("fill_wr%0d_cycles", i), cyc, 32'd2);
    end
    cpu_start(1'b1, 11'd24, 32'h104, 4'hF);
    wait_ack(6, cyc, rd);
    check("fill_wr4_stalled", cyc, 32'd0);
    acc_q.delete();
    vga_en = 1'b0;
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("fill_wr4_cycles", cyc, 32'd2);
    repeat (6) next_cycle();
    check("drain_nacc", acc_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("drain_acc%0d", i), {17'b0, acc_q[i]}, {17'b0, 4'hF, 11'(20 + i)});
    cpu_start(1'b0, 11'd24, 32'h0, 4'h0);
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("drain_rd24_data", rd, 32'h104);
    next_cycle();
`endif

    // reset during RD_WAIT
    cpu_start(1'b0, 11'd5, 32'h0, 4'h0);
    next_cycle();
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rstmid_ack", {31'b0, cpu_ack}, 32'h0);
    next_cycle();
    reset = 1'b0;
    acc_q.delete();
    cpu_start(1'b0, 11'd7, 32'h0, 4'h0);
    @(negedge clk);
    check("rstmid_ack_after", {31'b0, cpu_ack}, 32'h0);
    check("rstmid_rdata",     cpu_rdata, 32'h0);
    check("rstmid_new_en",    {31'b0, mem_en}, 32'h1);
    check("rstmid_new_addr",  {21'b0, mem_addr}, 32'd7);
    next_cycle();
    wait_ack(20, cyc, rd);
    cpu_req = 1'b0;
    check("rstmid_new_cycles", cyc, 32'd2);
    check("rstmid_new_data",   rd,  32'h07070707);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
